// File: rtl/data_memory.sv
// Word-addressed data memory with a memory-mapped output register.
// Writes fire on the rising transition of Store; reads are registered with one cycle of latency.
module data_memory #(
    parameter int          DEPTH   = 16,
    parameter logic [15:0] INIT3   = 16'h0004,
    parameter logic [15:0] IO_ADDR = 16'h00FF
) (
    input  logic        Clock,
    input  logic        Resetn,
    input  logic [15:0] Addr,
    input  logic [15:0] DataIn,
    input  logic        Store,
    output logic [15:0] DataOut,
    output logic        WrAck,
    output logic        AddrErr,
    output logic [15:0] IoOut,
    output logic [7:0]  WrCount
);

    localparam int          AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [15:0] DEPTH16 = 16'(DEPTH);

    logic [15:0]   ram [DEPTH];
    logic          store_q;
    logic          write_ev;
    logic          in_ram;
    logic          is_io;
    logic          mapped;
    logic [AW-1:0] ram_idx;

    assign write_ev = Store & ~store_q;
    assign in_ram   = (Addr < DEPTH16);
    assign is_io    = (Addr == IO_ADDR);
    assign mapped   = in_ram | is_io;
    assign ram_idx  = Addr[AW-1:0];

    // NOTE: every register, RAM words included, uses non-blocking assignment so the
    // read path below sees the pre-edge contents; write-first is done explicitly.
    always_ff @(posedge Clock) begin
        // store_q tracks Store even in reset, so a level held across release is not an edge
        store_q <= Store;
        if (Resetn) begin
            DataOut <= 16'h0000;
            WrAck   <= 1'b0;
            AddrErr <= 1'b0;
            IoOut   <= 16'h0000;
            WrCount <= 8'h00;
            // NOTE: the RAM has defined reset contents, so it is built from resettable
            // flops rather than a block RAM macro.
            for (int i = 0; i < DEPTH; i++) begin
                ram[i] <= (i == 3) ? INIT3 : 16'h0000;
            end
        end else begin
            WrAck   <= write_ev & mapped;
            AddrErr <= ~mapped;

            if (in_ram) begin
                DataOut <= write_ev ? DataIn : ram[ram_idx];
            end else if (is_io) begin
                DataOut <= write_ev ? DataIn : IoOut;
            end else begin
                DataOut <= 16'h0000;
            end

            if (write_ev && in_ram) begin
                ram[ram_idx] <= DataIn;
            end
            if (write_ev && !in_ram && is_io) begin
                IoOut <= DataIn;
            end
            if (write_ev && mapped && (WrCount != 8'hFF)) begin
                WrCount <= WrCount + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_data_memory.sv
// Self-checking bench for data_memory: directed scenarios plus randomized traffic
// compared every cycle against a behavioural model of the memory map.
module tb_data_memory;

    localparam int MDEPTH = 16;
    localparam int MIO    = 255;

    logic        Clock = 1'b0;
    logic        Resetn;
    logic [15:0] Addr;
    logic [15:0] DataIn;
    logic        Store;
    logic [15:0] DataOut;
    logic        WrAck;
    logic        AddrErr;
    logic [15:0] IoOut;
    logic [7:0]  WrCount;

    data_memory dut (
        .Clock   (Clock),
        .Resetn  (Resetn),
        .Addr    (Addr),
        .DataIn  (DataIn),
        .Store   (Store),
        .DataOut (DataOut),
        .WrAck   (WrAck),
        .AddrErr (AddrErr),
        .IoOut   (IoOut),
        .WrCount (WrCount)
    );

    always #5 Clock = ~Clock;

    int vectors    = 0;
    int miscompares = 0;
    bit check_en   = 1'b0;

    // Behavioural model state: what every output must read after the latest edge
    int m_mem [MDEPTH];
    int m_io;
    int m_cnt;
    int m_prev;
    int e_dout;
    int e_ack;
    int e_err;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    always @(posedge Clock) begin
        int a;
        int ev;
        a = int'(Addr);
        if (Resetn === 1'b1) begin
            for (int i = 0; i < MDEPTH; i++) m_mem[i] = (i == 3) ? 4 : 0;
            m_io   = 0;
            m_cnt  = 0;
            e_dout = 0;
            e_ack  = 0;
            e_err  = 0;
        end else begin
            ev = (Store === 1'b1 && m_prev == 0) ? 1 : 0;
            if (a < MDEPTH) begin
                e_dout = ev ? int'(DataIn) : m_mem[a];
                if (ev) m_mem[a] = int'(DataIn);
            end else if (a == MIO) begin
                e_dout = ev ? int'(DataIn) : m_io;
                if (ev) m_io = int'(DataIn);
            end else begin
                e_dout = 0;
            end
            e_err = (a < MDEPTH || a == MIO) ? 0 : 1;
            e_ack = (ev && !e_err) ? 1 : 0;
            if (e_ack && m_cnt < 255) m_cnt = m_cnt + 1;
        end
        m_prev = (Store === 1'b1) ? 1 : 0;
    end

    always @(negedge Clock) begin
        if (check_en) begin
            check("DataOut", DataOut, 16'(e_dout));
            check("WrAck",   {15'b0, WrAck},   16'(e_ack));
            check("AddrErr", {15'b0, AddrErr}, 16'(e_err));
            check("IoOut",   IoOut,   16'(m_io));
            check("WrCount", {8'b0, WrCount}, 16'(m_cnt));
        end
    end

    // Drive one cycle of inputs and return at the following falling edge
    task automatic cyc(input logic r, input logic [15:0] a, input logic [15:0] d, input logic s);
        Resetn = r;
        Addr   = a;
        DataIn = d;
        Store  = s;
        @(negedge Clock);
    endtask

    initial begin
        Resetn = 1'b1;
        Addr   = '0;
        DataIn = '0;
        Store  = 1'b0;
        @(negedge Clock);
        cyc(1'b1, 16'h0, 16'h0, 1'b0);
        check_en = 1'b1;
        check("rst DataOut", DataOut, 16'h0000);
        check("rst WrCount", {8'b0, WrCount}, 16'h0000);
        check("rst IoOut",   IoOut,   16'h0000);

        // Reset contents and unmapped-free reads
        cyc(1'b0, 16'd3, 16'h0, 1'b0);
        check("read word3", DataOut, 16'h0004);
        cyc(1'b0, 16'd5, 16'h0, 1'b0);
        check("read word5", DataOut, 16'h0000);

        // Held Store yields one write
        cyc(1'b0, 16'd7, 16'hBEEF, 1'b1);
        check("held WrAck first", {15'b0, WrAck}, 16'h0001);
        cyc(1'b0, 16'd7, 16'hBEEF, 1'b1);
        check("held WrAck second", {15'b0, WrAck}, 16'h0000);
        cyc(1'b0, 16'd7, 16'hBEEF, 1'b1);
        cyc(1'b0, 16'd7, 16'hBEEF, 1'b1);
        cyc(1'b0, 16'd7, 16'h0000, 1'b0);
        check("read word7", DataOut, 16'hBEEF);
        check("count one", {8'b0, WrCount}, 16'h0001);

        // Address/data changes during a held Store are ignored
        cyc(1'b0, 16'd9,  16'h1234, 1'b1);
        cyc(1'b0, 16'd10, 16'h5678, 1'b1);
        cyc(1'b0, 16'd9,  16'h0000, 1'b0);
        check("read word9", DataOut, 16'h1234);
        cyc(1'b0, 16'd10, 16'h0000, 1'b0);
        check("read word10", DataOut, 16'h0000);

        // Memory-mapped register and unmapped write
        cyc(1'b0, 16'h00FF, 16'h00A5, 1'b1);
        check("io IoOut", IoOut, 16'h00A5);
        check("io WrAck", {15'b0, WrAck}, 16'h0001);
        cyc(1'b0, 16'h00FF, 16'h0000, 1'b0);
        check("io read", DataOut, 16'h00A5);
        cyc(1'b0, 16'h0040, 16'h0077, 1'b1);
        check("unmapped AddrErr", {15'b0, AddrErr}, 16'h0001);
        check("unmapped WrAck", {15'b0, WrAck}, 16'h0000);
        check("unmapped DataOut", DataOut, 16'h0000);
        check("unmapped WrCount", {8'b0, WrCount}, 16'h0003);
        cyc(1'b0, 16'd3, 16'h0000, 1'b0);
        check("AddrErr clears", {15'b0, AddrErr}, 16'h0000);

        // Randomized traffic checked by the model every cycle
        for (int i = 0; i < 600; i++) begin
            logic [15:0] a;
            case ($urandom_range(0, 9))
                0:       a = 16'h00FF;
                1:       a = 16'($urandom);
                default: a = 16'($urandom_range(0, MDEPTH - 1));
            endcase
            cyc(($urandom_range(0, 59) == 0), a, 16'($urandom), 1'($urandom));
        end

        // Saturation of the write counter
        cyc(1'b1, 16'h0, 16'h0, 1'b0);
        for (int i = 0; i < 300; i++) begin
            cyc(1'b0, 16'd0, 16'(i), 1'b1);
            cyc(1'b0, 16'd0, 16'(i), 1'b0);
        end
        check("count saturated", {8'b0, WrCount}, 16'h00FF);

        // Store held high across reset and release: no write
        cyc(1'b1, 16'd0, 16'h1111, 1'b1);
        cyc(1'b1, 16'd0, 16'h1111, 1'b1);
        cyc(1'b0, 16'd0, 16'h1111, 1'b1);
        check("release DataOut", DataOut, 16'h0000);
        check("release WrAck", {15'b0, WrAck}, 16'h0000);
        cyc(1'b0, 16'd3, 16'h2222, 1'b1);
        check("release word3", DataOut, 16'h0004);
        check("release WrCount", {8'b0, WrCount}, 16'h0000);
        cyc(1'b0, 16'd0, 16'h0000, 1'b0);
        check("release word0", DataOut, 16'h0000);

        check_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
